// File: rtl/gf180mcu_clkgate_seq_pkg.sv
// gf180mcu_clkgate_seq_pkg
// Shared definitions for the clock-enable sequencer. It holds the default
// branch count, stagger and hold constants, the counter-width helper and the
// per-branch on/off state type.
package gf180mcu_clkgate_seq_pkg;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned STAGGER_DEF = 4;
    localparam int unsigned HOLD_DEF    = 8;

    typedef enum logic {
        BR_OFF = 1'b0,
        BR_ON  = 1'b1
    } branch_state_e;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 32'd1 : 32'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/gf180mcu_clkgate_seq_if.sv
// gf180mcu_clkgate_seq_if
// Request/enable bundle between the branch requesters and the sequencer.
//   REQ  : per-branch clock request (driven by the requesters, master)
//   EN   : per-branch clock-gate enable (driven by the sequencer, slave)
//   ACK  : per-branch "clock running" (driven by the sequencer)
//   BUSY : turn-on work outstanding (driven by the sequencer)
interface gf180mcu_clkgate_seq_if
    import gf180mcu_clkgate_seq_pkg::*;
#(
    parameter int unsigned N = N_DEF
);

    logic [N-1:0] REQ;
    logic [N-1:0] EN;
    logic [N-1:0] ACK;
    logic         BUSY;

    modport master (output REQ, input EN, input ACK, input BUSY);
    modport slave  (input REQ, output EN, output ACK, output BUSY);

endinterface

// File: rtl/gf180mcu_clkgate_seq_rr_arb.sv
// gf180mcu_clkgate_seq_rr_arb
// Combinational round-robin picker.
//   pending : branches asking to be turned on
//   ptr     : index with the highest priority this cycle
//   grant   : one-hot winner (first pending index at or above ptr, wrapping)
//   valid   : some branch is pending
module gf180mcu_clkgate_seq_rr_arb
    import gf180mcu_clkgate_seq_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    localparam int unsigned PW = cnt_w(N - 1)
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Walk the ring starting at ptr; the first pending index wins.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!valid && pending[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_clkgate_seq.sv
// gf180mcu_clkgate_seq
// Clock-enable sequencer for gated clock branches. Branch turn-ons are granted
// one at a time, at least STAGGER cycles apart, round-robin among contending
// requesters; a branch turns off after HOLD consecutive low request samples.
// Ports:
//   CLK      : free-running root clock
//   RST      : synchronous active-high reset
//   TE       : test enable, present only with GF180MCU_CLKGATE_SEQ_TE_EN defined;
//              forces every branch on while high
//   bus      : slave side of gf180mcu_clkgate_seq_if (REQ in, EN/ACK/BUSY out)
//   VDD/VSS  : supply pins, no functional effect
module gf180mcu_clkgate_seq
    import gf180mcu_clkgate_seq_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned STAGGER = STAGGER_DEF,
    parameter int unsigned HOLD    = HOLD_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
`ifdef GF180MCU_CLKGATE_SEQ_TE_EN
    input  logic                         TE,
`endif
    gf180mcu_clkgate_seq_if.slave        bus,
    inout  wire                          VDD,
    inout  wire                          VSS
);

    localparam int unsigned PW = cnt_w(N - 1);
    localparam int unsigned SW = cnt_w(STAGGER - 1);
    localparam int unsigned HW = cnt_w(HOLD);

    localparam logic [SW-1:0] SC_LOAD = SW'(STAGGER - 1);
    localparam logic [HW-1:0] HC_LOAD = HW'(HOLD);

    // Supply pins carry no logic.
    wire unused_supply = VDD ^ VSS;

    branch_state_e br_q [N];
    branch_state_e br_d [N];
    logic [HW-1:0] hc_q [N];
    logic [HW-1:0] hc_d [N];
    logic [N-1:0]  ack_q, ack_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [PW-1:0] ptr_q, ptr_d;
`ifdef GF180MCU_CLKGATE_SEQ_TE_EN
    logic          te_q, te_d;
`endif

    logic [N-1:0]  en_vec;
    logic [N-1:0]  pending;
    logic [N-1:0]  grant;
    logic          grant_valid;

    // Enable vector straight from the branch state flops.
    always_comb begin
        en_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            en_vec[i] = (br_q[i] == BR_ON);
        end
    end

    assign pending = bus.REQ & ~en_vec;

    gf180mcu_clkgate_seq_rr_arb #(
        .N (N)
    ) u_rr_arb (
        .pending (pending),
        .ptr     (ptr_q),
        .grant   (grant),
        .valid   (grant_valid)
    );

    // Next-state: hold countdown, staggered grant, optional test override.
    always_comb begin
        br_d  = br_q;
        hc_d  = hc_q;
        ack_d = ack_q;
        sc_d  = sc_q;
        ptr_d = ptr_q;
`ifdef GF180MCU_CLKGATE_SEQ_TE_EN
        te_d  = TE;
`endif

        // A low request on an enabled branch counts down; a high one reloads.
        for (int unsigned i = 0; i < N; i++) begin
            if (br_q[i] == BR_ON) begin
                if (bus.REQ[i]) begin
                    hc_d[i] = HC_LOAD;
                end else begin
                    if (hc_q[i] <= HW'(1)) begin
                        br_d[i] = BR_OFF;
                    end
                    hc_d[i] = (hc_q[i] == '0) ? '0 : hc_q[i] - HW'(1);
                end
            end
        end

        // Only pending (currently off) branches can win, so this never
        // collides with a turn-off on the same edge.
        if (sc_q == '0) begin
            if (grant_valid) begin
                sc_d = SC_LOAD;
                for (int unsigned i = 0; i < N; i++) begin
                    if (grant[i]) begin
                        br_d[i] = BR_ON;
                        hc_d[i] = HC_LOAD;
                        ptr_d   = (i == N - 1) ? '0 : PW'(i + 1);
                    end
                end
            end
        end else begin
            sc_d = sc_q - SW'(1);
        end

        // ACK lags a turn-on by one edge and drops together with EN.
        for (int unsigned i = 0; i < N; i++) begin
            ack_d[i] = (br_q[i] == BR_ON) && (br_d[i] == BR_ON);
        end

`ifdef GF180MCU_CLKGATE_SEQ_TE_EN
        if (TE) begin
            for (int unsigned i = 0; i < N; i++) begin
                br_d[i] = BR_ON;
                hc_d[i] = HC_LOAD;
            end
            ack_d = '1;
            sc_d  = '0;
            ptr_d = ptr_q;
        end else if (te_q) begin
            // Leaving test mode: every branch restarts a full hold window.
            for (int unsigned i = 0; i < N; i++) begin
                br_d[i] = br_q[i];
                hc_d[i] = HC_LOAD;
            end
            ack_d = ack_q;
            sc_d  = '0;
            ptr_d = ptr_q;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < N; i++) begin
                br_q[i] <= BR_OFF;
                hc_q[i] <= '0;
            end
            ack_q <= '0;
            sc_q  <= '0;
            ptr_q <= '0;
`ifdef GF180MCU_CLKGATE_SEQ_TE_EN
            te_q  <= 1'b0;
`endif
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                br_q[i] <= br_d[i];
                hc_q[i] <= hc_d[i];
            end
            ack_q <= ack_d;
            sc_q  <= sc_d;
            ptr_q <= ptr_d;
`ifdef GF180MCU_CLKGATE_SEQ_TE_EN
            te_q  <= te_d;
`endif
        end
    end

    assign bus.EN   = en_vec;
    assign bus.ACK  = ack_q;
    // Combinational status, masked during reset.
    assign bus.BUSY = ~RST & ((|pending) | (sc_q != '0));

endmodule

// File: doc/gf180mcu_clkgate_seq.md
# gf180mcu_clkgate_seq

Clock-enable sequencer for gated clock branches built from the 7-track 5 V clock cells, such as inverter drivers and clock gates. Requesters ask for their branch clock. The block turns branches on one at a time, spacing turn-ons by a fixed number of cycles to limit supply di/dt, and serves contending requesters round-robin. Branches turn off only after their request has been idle for a fixed hold time. It sits in the always-on domain, next to the clock tree root.

## Interface
Parameters:
- N, default 4: number of gated branches (2..16).
- STAGGER, default 4: minimum number of cycles between two branch turn-ons (≥1).
- HOLD, default 8: number of consecutive low REQ samples before a branch is turned off (≥1).

Ports:
- CLK  input  1  free-running root clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- REQ  input  N  per-branch clock request, level-sensitive.
- EN  output  N  registered enable to each branch clock gate.
- ACK  output  N  branch clock running; registered.
- BUSY  output  1  turn-on work outstanding.
- VDD, VSS  inout  1  supply pins; no functional effect.

## Operation
- Pending set is REQ & ~EN.
- Stagger counter SC:
  - When SC==0 and any branch is pending, grant exactly one branch: set its EN and load SC = STAGGER-1.
  - When SC != 0, decrement SC by 1 per cycle and make no grant.
- Round-robin pointer P:
  - Search the pending set from index P upward, wrapping past N-1 to 0.
  - After a grant to branch g, P = (g+1) mod N.
  - P resets to 0, so index 0 has the highest priority after reset.
- Per-branch hold counter HC[i], width $clog2(HOLD+1):
  - While EN[i]=1 and REQ[i]=1: reload HC[i] = HOLD.
  - While EN[i]=1 and REQ[i]=0: if HC[i]==1, clear EN[i]; otherwise decrement HC[i].
  - Granting EN[i] also loads HC[i] = HOLD.
- ACK[i]:
  - Rises one cycle after EN[i] rises.
  - Falls on the same edge EN[i] falls.
- Turn-off is not staggered; any number of branches may turn off on the same edge.
- A turn-off and a grant on the same edge are both performed.
- A REQ pulse that drops before its grant leaves no trace.
- A REQ that rises while its branch is already on only reloads HC.
- BUSY = ~RST & ((|pending) | (SC != 0)). This is the only combinational output.

## Timing
- Reset values: EN=0, ACK=0, SC=0, P=0, HC=0. BUSY is 0 while RST=1.
- Reset takes priority over every other event, including a reset in the middle of a stagger or hold countdown: all branches are dropped on that edge.
- Turn-on latency: REQ[i] sampled high at edge k, with SC==0 and branch i winning, gives EN[i]=1 after edge k and ACK[i]=1 after edge k+1.
- Consecutive grants are at least STAGGER edges apart. STAGGER=1 allows one grant every cycle.
- Turn-off: REQ[i] sampled low for HOLD consecutive edges, k..k+HOLD-1, clears EN[i] and ACK[i] at edge k+HOLD-1.
- A single high REQ sample during the countdown restarts the full HOLD count.

## Configuration
- Macro GF180MCU_CLKGATE_SEQ_TE_EN.
  - When defined: adds input TE (1 bit). While TE=1, every EN and ACK bit is forced to 1 on the next edge, ignoring the stagger and hold rules, and SC is held at 0. When TE falls, HC for all branches is loaded with HOLD and normal hold behaviour resumes.
  - When undefined: there is no TE port and no override logic.

## Structure
- Shared package gf180mcu_clkgate_seq_pkg holds:
  - the default constants for N, STAGGER and HOLD;
  - the counter-width function;
  - the branch state typedef (OFF, ON).
- One sub-module, gf180mcu_clkgate_seq_rr_arb: a combinational round-robin picker with inputs pending and P, and outputs grant one-hot and valid.
- Counters and pointer live in the top level.

## Test plan
- Reset with REQ=4'b1111 held, RST high for 2 cycles → EN=0, ACK=0, BUSY=0 throughout; grants start on the first edge after RST falls.
- REQ=4'b1111 from cycle 0, STAGGER=4 → EN[0], EN[1], EN[2], EN[3] rise at edges 0, 4, 8, 12; each ACK one edge later; BUSY falls after edge 15.
- Contention after a grant to branch 2, with REQ[0] and REQ[3] pending together → branch 3 granted first, branch 0 granted STAGGER edges later.
- HOLD=8, REQ[1] low for 7 cycles then high → EN[1] stays 1. REQ[1] low for 8 cycles → EN[1] and ACK[1] fall on the 8th low-sample edge.
- RST pulsed mid-countdown (SC=2, two branches on) → all cleared; a new REQ[3] is granted on the first edge after reset.
- With GF180MCU_CLKGATE_SEQ_TE_EN defined, TE=1 with REQ=0 → EN=4'b1111 next edge. TE falls → branches drop HOLD edges later.
